// File: rtl/led_pattern_gen_if.sv
// Signal bundle between the key/switch control logic and the LED chaser.
// The master side supplies run/mode/speed; the slave (chaser) returns led and step_tick.
interface led_pattern_gen_if #(
  parameter int LED_NUM = 4
);
  logic               run;
  logic [1:0]         mode;
  logic [1:0]         speed;
  logic [LED_NUM-1:0] led;
  logic               step_tick;

  modport master (
    output run, mode, speed,
    input  led, step_tick
  );

  modport slave (
    input  run, mode, speed,
    output led, step_tick
  );
endinterface

// File: rtl/led_pattern_gen.sv
// LED chaser: four patterns advanced by a step counter whose period is CNT_MAX >> speed clocks.
// A mode change restarts the pattern from bit0 and clears the partial period.
module led_pattern_gen #(
  parameter int LED_NUM = 4,
  parameter int CNT_MAX = 50_000_000,
  parameter int CNT_W   = 26
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  led_pattern_gen_if.slave bus
);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [CNT_W-1:0]   CNT_MAX_W = CNT_W'(CNT_MAX);
  localparam logic [LED_NUM-1:0] LED_ONE   = LED_NUM'(1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic               tick_q, tick_d;
  logic [1:0]         mode_q;
  dir_e               dir_q, dir_d;
  logic [CNT_W-1:0]   thr;

  assign thr = (CNT_MAX_W >> bus.speed) - CNT_W'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      led_q  <= LED_ONE;
      tick_q <= 1'b0;
      mode_q <= 2'd0;
      dir_q  <= DIR_LEFT;
    end else begin
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      tick_q <= tick_d;
      mode_q <= bus.mode;
      dir_q  <= dir_d;
    end
  end

  // Priority: mode change, then pause, then the period compare (>= so a faster speed applies at once).
  always_comb begin
    cnt_d  = cnt_q;
    led_d  = led_q;
    dir_d  = dir_q;
    tick_d = 1'b0;

    if (bus.mode != mode_q) begin
      cnt_d = '0;
      led_d = LED_ONE;
      dir_d = DIR_LEFT;
    end else if (bus.run) begin
      if (cnt_q >= thr) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        case (mode_q)
          2'd0: led_d = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
          2'd1: led_d = {led_q[0], led_q[LED_NUM-1:1]};
          2'd2: begin
            // Turn around on the end LED itself so each end stays lit for a single step.
            if (dir_q == DIR_LEFT && led_q[LED_NUM-1]) begin
              dir_d = DIR_RIGHT;
              led_d = led_q >> 1;
            end else if (dir_q == DIR_RIGHT && led_q[0]) begin
              dir_d = DIR_LEFT;
              led_d = led_q << 1;
            end else if (dir_q == DIR_LEFT) begin
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
          default: begin
            if (&led_q)
              led_d = '0;
            else if (led_q == '0)
              led_d = LED_ONE;
            else
              led_d = (led_q << 1) | LED_ONE;
          end
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.led       = led_q;
  assign bus.step_tick = tick_q;

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised next-generation LED chaser for the board LED bank. It drives LED_NUM outputs from a step-period counter derived from sys_clk. It supports four run-time selectable patterns (rotate left, rotate right, ping-pong, bar fill), a 4-level speed select and a run/pause control. It sits directly on the LED pins and takes its mode, speed and run inputs from the key/switch handling logic.

Parameters:
LED_NUM, 4, number of LEDs driven; legal range 2..32.
CNT_MAX, 50_000_000, sys_clk cycles per step at speed 0 (1 s at 50 MHz); set to 8 in simulation.
CNT_W, 26, counter width; must satisfy 2^CNT_W > CNT_MAX.

Ports:
sys_clk  in  1  system clock, 50 MHz.
sys_rst_n  in  1  asynchronous active-low reset.
run  in  1  1 = advance pattern, 0 = pause (counter and LEDs hold).
mode  in  2  0 = rotate left, 1 = rotate right, 2 = ping-pong, 3 = bar fill.
speed  in  2  step period = CNT_MAX >> speed clocks (speed 0 = 1x, 3 = 8x faster).
led  out  LED_NUM  LED drive, 1 = on.
step_tick  out  1  one-cycle pulse on the cycle the pattern advances.

Behaviour:
- One clock (sys_clk). Asynchronous active-low reset (sys_rst_n). All state resets asynchronously and releases on a sys_clk edge.
- Reset values:
  - led = 1 (bit0 on only); step_tick = 0; counter = 0.
  - dir = left; mode_q = 0.
- Period and counter:
  - thr = (CNT_MAX >> speed) − 1, computed at CNT_W width.
  - When run = 1, the counter increments each clock.
  - When the counter ≥ thr, the counter clears to 0 and step_tick pulses for one cycle. Because the comparison is ≥, a speed increase mid-count takes effect immediately with no long wrap.
  - Step period = thr + 1 clocks.
- Pause: when run = 0, the counter, led and dir hold and step_tick = 0. When run returns to 1, counting resumes from the held count.
- Mode change:
  - mode_q registers mode every clock.
  - When mode ≠ mode_q, on that clock: led ← 1, counter ← 0, dir ← left, no step_tick.
  - This takes priority over tick and run.
- Pattern update, applied only on tick:
  - Mode 0: rotate left; MSB wraps to bit0. For LED_NUM = 4: 0001 → 0010 → 0100 → 1000 → 0001.
  - Mode 1: rotate right; bit0 wraps to MSB. 0001 → 1000 → 0100 → 0010 → 0001.
  - Mode 2 (ping-pong):
    - dir = left and MSB set: dir ← right, shift right.
    - dir = right and bit0 set: dir ← left, shift left.
    - Otherwise shift in dir.
    - Sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, … The end LEDs are lit for exactly one step each.
  - Mode 3 (bar fill):
    - led = all ones: next is all zeros.
    - led = 0: next is 1.
    - Otherwise next is (led << 1) | 1.
    - Sequence: 0001, 0011, 0111, 1111, 0000, 0001, …
- Latency: led and step_tick are registered and change on the same clock edge. led never changes except on step_tick cycles, mode changes or reset.
- Simultaneous events: reset > mode change > run = 0 > tick.
- Reset mid-step: the pattern and counter restart from their reset values; the partial period is discarded.

Test Plan:
- CNT_MAX = 8, mode 0, speed 0, run 1, release reset → step_tick every 8 clocks; led 0001, 0010, 0100, 1000, 0001 on successive ticks.
- Mode 2 for 8 ticks → led 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100; the 1000 and 0001 states each last exactly one step.
- Mode 3 for 5 ticks → 0011, 0111, 1111, 0000, 0001. Then switch to mode 1 mid-period → the next clock shows led = 0001, counter = 0, and the first tick 8 clocks later gives 1000.
- Speed 0 with counter = 5, switch to speed 2 (thr = 1) → tick on the next clock, then ticks every 2 clocks.
- run = 0 for 20 clocks mid-period → led and counter frozen, no step_tick. Then run = 1 → the tick arrives after the remaining clocks of the interrupted period.
- Assert sys_rst_n low asynchronously (between edges) while led = 0100 in mode 2 → led = 0001 immediately. After release, the first tick gives 0010 with dir = left.
